// File: rtl/riscv_dmi_pkg.sv
// Shared types for the DMI arbiter: address width, op/status encodings,
// latched request/response records and the sequencer state encoding.
// No ports; imported by riscv_rr_arb2 and riscv_dmi_arbiter.
package riscv_dmi_pkg;

  localparam int DMI_ABITS = 7;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_ST_OK     = 2'd0,
    DMI_ST_FAILED = 2'd2,
    DMI_ST_BUSY   = 2'd3
  } dmi_status_e;

  // op is kept as raw bits: the reserved encoding 3 must survive latching.
  typedef struct packed {
    logic [DMI_ABITS-1:0] addr;
    logic [31:0]          data;
    logic [1:0]           op;
  } dmi_req_t;

  // op carries whatever status the DM returned, so it is raw bits too.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dmi_arb_state_e;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Combinational two-way round-robin picker.
// Ports: valid_i[1:0] requests, last_grant_i previous winner,
//        grant_o winning index, grant_valid_o any request present.
module riscv_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  // On a tie the requester that did not win last time gets the grant.
  assign grant_o       = (&valid_i) ? ~last_grant_i : valid_i[1];
  assign grant_valid_o = |valid_i;

endmodule

// File: rtl/riscv_dmi_arbiter.sv
// Two-requester DMI arbiter/sequencer: round-robin grant, one transaction in
// flight, NOP/reserved ops completed locally, optional DM timeout.
// Ports: tck_i/ntrst_i clock and async active-low reset; req0/req1 request
//        ports; resp0/resp1 response ports with shared resp_data_o/resp_op_o;
//        dm_* request/response channel to the Debug Module.
// Build macro RISCV_DMI_ARB_TIMEOUT_EN enables the TIMEOUT_CYCLES watchdog.
module riscv_dmi_arbiter
  import riscv_dmi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 tck_i,
  input  logic                 ntrst_i,
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [DMI_ABITS-1:0] req0_addr_i,
  input  logic [31:0]          req0_data_i,
  input  logic [1:0]           req0_op_i,
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [DMI_ABITS-1:0] req1_addr_i,
  input  logic [31:0]          req1_data_i,
  input  logic [1:0]           req1_op_i,
  output logic                 resp0_valid_o,
  input  logic                 resp0_ready_i,
  output logic                 resp1_valid_o,
  input  logic                 resp1_ready_i,
  output logic [31:0]          resp_data_o,
  output logic [1:0]           resp_op_o,
  output logic                 dm_req_valid_o,
  input  logic                 dm_req_ready_i,
  output logic [DMI_ABITS-1:0] dm_addr_o,
  output logic [31:0]          dm_data_o,
  output logic [1:0]           dm_op_o,
  input  logic                 dm_resp_valid_i,
  input  logic [31:0]          dm_resp_data_i,
  input  logic [1:0]           dm_resp_op_i
);

  dmi_arb_state_e state_q, state_d;
  dmi_req_t       req_q, req_d, win_req;
  dmi_resp_t      resp_q, resp_d;
  logic           gid_q, gid_d;
  logic           last_q, last_d;
  logic           grant, grant_vld;
  logic           timeout;

  riscv_rr_arb2 u_arb (
    .valid_i       ({req1_valid_i, req0_valid_i}),
    .last_grant_i  (last_q),
    .grant_o       (grant),
    .grant_valid_o (grant_vld)
  );

  always_comb begin
    win_req = '0;
    if (grant) begin
      win_req.addr = req1_addr_i;
      win_req.data = req1_data_i;
      win_req.op   = req1_op_i;
    end else begin
      win_req.addr = req0_addr_i;
      win_req.data = req0_data_i;
      win_req.op   = req0_op_i;
    end
  end

`ifdef RISCV_DMI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;

  // Held at zero while idle so it reads 0 on the first ISSUE cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign timeout = (state_q == ST_ISSUE || state_q == ST_WAIT) && (cnt_q == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = resp_q;
    gid_d   = gid_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          req_d = win_req;
          gid_d = grant;
          if (win_req.op == DMI_OP_READ || win_req.op == DMI_OP_WRITE) begin
            state_d = ST_ISSUE;
          end else begin
            state_d     = ST_RESP;
            resp_d.data = '0;
            resp_d.op   = (win_req.op == 2'd3) ? DMI_ST_FAILED : DMI_ST_OK;
          end
        end
      end
      ST_ISSUE: begin
        // Timeout outranks a same-cycle accept: the late reply is dropped.
        if (timeout) begin
          state_d     = ST_RESP;
          resp_d.data = '0;
          resp_d.op   = DMI_ST_FAILED;
        end else if (dm_req_ready_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A real response beats a coincident timeout.
        if (dm_resp_valid_i) begin
          state_d     = ST_RESP;
          resp_d.data = dm_resp_data_i;
          resp_d.op   = dm_resp_op_i;
        end else if (timeout) begin
          state_d     = ST_RESP;
          resp_d.data = '0;
          resp_d.op   = DMI_ST_FAILED;
        end
      end
      ST_RESP: begin
        if (gid_q ? resp1_ready_i : resp0_ready_i) begin
          last_d  = gid_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tck_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      resp_q  <= '0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
    end
  end

  assign req0_ready_o   = (state_q == ST_IDLE) && grant_vld && !grant;
  assign req1_ready_o   = (state_q == ST_IDLE) && grant_vld && grant;
  assign dm_req_valid_o = (state_q == ST_ISSUE);
  assign dm_addr_o      = req_q.addr;
  assign dm_data_o      = req_q.data;
  assign dm_op_o        = req_q.op;
  assign resp0_valid_o  = (state_q == ST_RESP) && !gid_q;
  assign resp1_valid_o  = (state_q == ST_RESP) && gid_q;
  assign resp_data_o    = resp_q.data;
  assign resp_op_o      = resp_q.op;

endmodule
